fu_exec_unit: RTL and testbench

- Functional-unit end of the reservation-station-to-execute channel. It is the responder for the RS issue handshake.
- Accepts one resolved instruction per cycle from a reservation station and computes the ALU, branch and address result.
- Returns same-cycle resolution fields to the RS.
- Queues completed results in a 2-entry output buffer that drains to the CDB arbiter under a valid/ready handshake.
- One instance sits behind each ALU reservation station; misprediction flush clears it.

---
 rtl/fu_exec_pkg.sv | 49 ++++
 rtl/fu_result_buffer.sv | 64 ++++++
 rtl/fu_exec_unit.sv | 136 +++++++++++++
 tb/tb_fu_exec_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fu_exec_pkg.sv
// Shared encodings and result record for the ALU functional-unit channel.
// Used by decode, the reservation stations and the execute unit.
package fu_exec_pkg;

   localparam int FU_DATA_W = 32;
   localparam int FU_TAG_W  = 6;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLT  = 3'd3,
      BR_BGE  = 3'd4,
      BR_BLTU = 3'd5,
      BR_BGEU = 3'd6,
      BR_JUMP = 3'd7
   } branch_sel_e;

   localparam int CTRL_WIDTH      = 11;
   localparam int CTRL_ALU_OP_LSB = 0;
   localparam int CTRL_ALU_OP_MSB = 3;
   localparam int CTRL_REG_WRITE  = 4;
   localparam int CTRL_MEM_OP     = 5;
   localparam int CTRL_JALR       = 6;
   localparam int CTRL_A_IS_PC    = 7;

   typedef struct packed {
      logic [FU_TAG_W-1:0]  tag;
      logic [FU_DATA_W-1:0] data;
      logic                 reg_write;
      logic                 misprediction;
      logic [FU_DATA_W-1:0] correct_pc;
   } fu_result_t;

endpackage

// File: rtl/fu_result_buffer.sv
// Two-entry FIFO of completed results feeding the CDB arbiter.
// Flush empties it; reset additionally clears the stored payloads.
module fu_result_buffer
   import fu_exec_pkg::*;
#(
   parameter type T = fu_result_t
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush_i,
   input  logic       push_i,
   input  T           push_data_i,
   input  logic       pop_ready_i,
   output logic       valid_o,
   output T           head_o,
   output logic [1:0] count_o
);

   T           mem_q [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic       pop;

   assign pop = (count_q != 2'd0) && pop_ready_i;

   // NOTE: every next-state signal gets its hold value first so no path infers a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_i) wr_ptr_d = ~wr_ptr_q;
         if (pop)    rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + 2'(push_i) - 2'(pop);
      end
   end

   // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         // NOTE: the two payload slots are reset because the CDB outputs must read 0 out of reset.
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign valid_o = (count_q != 2'd0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fu_exec_unit.sv
// ALU/branch execute stage behind one reservation station: resolves the
// presented op combinationally and queues its result for the CDB.
module fu_exec_unit
   import fu_exec_pkg::*;
#(
   parameter int DATA_WIDTH          = FU_DATA_W,
   parameter int PHYS_REG_ADDR_WIDTH = FU_TAG_W,
   parameter int OUT_DEPTH           = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           issue_valid,
   output logic                           issue_ready,
   input  logic [CTRL_WIDTH-1:0]          control_signals,
   input  logic [DATA_WIDTH-1:0]          pc,
   input  logic [DATA_WIDTH-1:0]          data_a,
   input  logic [DATA_WIDTH-1:0]          data_b,
   input  logic [DATA_WIDTH-1:0]          store_data,
   input  logic [PHYS_REG_ADDR_WIDTH-1:0] rd_phys_addr,
   input  logic [DATA_WIDTH-1:0]          pc_value_at_prediction,
   input  logic [2:0]                     branch_sel,
   input  logic                           branch_prediction,
   output logic [DATA_WIDTH-1:0]          data_result,
   output logic                           mem_addr_calculation,
   output logic                           misprediction,
   output logic                           is_branch,
   output logic [DATA_WIDTH-1:0]          correct_pc,
   output logic                           cdb_valid,
   input  logic                           cdb_ready,
   output logic [PHYS_REG_ADDR_WIDTH-1:0] cdb_tag,
   output logic [DATA_WIDTH-1:0]          cdb_data,
   output logic                           cdb_reg_write,
   output logic                           cdb_misprediction,
   output logic [DATA_WIDTH-1:0]          cdb_correct_pc
);

   alu_op_e                 alu_op;
   branch_sel_e             br_sel;
   logic [DATA_WIDTH-1:0]   op_a, op_b, alu_res, target, pc_plus4;
   logic [4:0]              shamt;
   logic                    cond, jump, taken, branch_any, mispred_raw;
   logic [1:0]              count;
   logic                    accept;
   fu_result_t              push_rec, head_rec;
   logic                    unused_ctrl;

   assign alu_op      = alu_op_e'(control_signals[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]);
   assign br_sel      = branch_sel_e'(branch_sel);
   assign unused_ctrl = ^{control_signals[10:8], OUT_DEPTH[0]};

   assign op_a     = control_signals[CTRL_A_IS_PC] ? pc : data_a;
   assign op_b     = data_b;
   assign shamt    = op_b[4:0];
   assign pc_plus4 = pc + DATA_WIDTH'(4);

   always_comb begin
      alu_res = '0;
      case (alu_op)
         ALU_ADD:    alu_res = op_a + op_b;
         ALU_SUB:    alu_res = op_a - op_b;
         ALU_SLL:    alu_res = op_a << shamt;
         ALU_SLT:    alu_res = DATA_WIDTH'($signed(op_a) < $signed(op_b));
         ALU_SLTU:   alu_res = DATA_WIDTH'(op_a < op_b);
         ALU_XOR:    alu_res = op_a ^ op_b;
         ALU_SRL:    alu_res = op_a >> shamt;
         ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_OR:     alu_res = op_a | op_b;
         ALU_AND:    alu_res = op_a & op_b;
         ALU_PASS_B: alu_res = op_b;
         default:    alu_res = '0;
      endcase
   end

   // Conditional branches compare the raw rs1/rs2 values, never the immediate.
   always_comb begin
      cond = 1'b0;
      case (br_sel)
         BR_BEQ:  cond = (data_a == store_data);
         BR_BNE:  cond = (data_a != store_data);
         BR_BLT:  cond = ($signed(data_a) <  $signed(store_data));
         BR_BGE:  cond = ($signed(data_a) >= $signed(store_data));
         BR_BLTU: cond = (data_a <  store_data);
         BR_BGEU: cond = (data_a >= store_data);
         default: cond = 1'b0;
      endcase
   end

   assign jump       = (br_sel == BR_JUMP);
   assign branch_any = (br_sel != BR_NONE);
   assign taken      = cond || jump;
   assign target     = (jump && control_signals[CTRL_JALR])
                     ? ((data_a + data_b) & ~DATA_WIDTH'(1))
                     : (pc + data_b);
   assign mispred_raw = branch_any &&
                        ((taken != branch_prediction) ||
                         (taken && (pc_value_at_prediction != target)));

   assign data_result          = issue_valid ? (jump ? pc_plus4 : alu_res) : '0;
   assign correct_pc           = issue_valid ? (taken ? target : pc_plus4) : '0;
   assign misprediction        = issue_valid && mispred_raw;
   assign is_branch            = issue_valid && branch_any;
   assign mem_addr_calculation = issue_valid && control_signals[CTRL_MEM_OP];

   // A full buffer can still accept when the head drains in the same cycle.
   assign issue_ready = !flush && ((count < 2'd2) || cdb_ready);
   assign accept      = issue_valid && issue_ready;

   always_comb begin
      push_rec               = '0;
      push_rec.tag           = rd_phys_addr;
      push_rec.data          = data_result;
      push_rec.reg_write     = control_signals[CTRL_REG_WRITE];
      push_rec.misprediction = misprediction;
      push_rec.correct_pc    = correct_pc;
   end

   fu_result_buffer #(.T(fu_result_t)) u_buf (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush),
      .push_i      (accept),
      .push_data_i (push_rec),
      .pop_ready_i (cdb_ready),
      .valid_o     (cdb_valid),
      .head_o      (head_rec),
      .count_o     (count)
   );

   assign cdb_tag           = head_rec.tag;
   assign cdb_data          = head_rec.data;
   assign cdb_reg_write     = head_rec.reg_write;
   assign cdb_misprediction = head_rec.misprediction;
   assign cdb_correct_pc    = head_rec.correct_pc;

endmodule

// File: tb/tb_fu_exec_unit.sv
// Scoreboard bench for fu_exec_unit: directed issues push expected CDB
// records, an independent monitor pops them as the CDB handshakes.
module tb_fu_exec_unit;
   import fu_exec_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic [10:0] control_signals = '0;
   logic [31:0] pc = '0, data_a = '0, data_b = '0, store_data = '0;
   logic [5:0]  rd_phys_addr = '0;
   logic [31:0] pc_value_at_prediction = '0;
   logic [2:0]  branch_sel = '0;
   logic        branch_prediction = 1'b0;
   logic [31:0] data_result, correct_pc;
   logic        mem_addr_calculation, misprediction, is_branch;
   logic        cdb_valid;
   logic        cdb_ready = 1'b0;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data, cdb_correct_pc;
   logic        cdb_reg_write, cdb_misprediction;

   int n_vec = 0;
   int n_err = 0;
   fu_result_t sb[$];

   fu_exec_unit dut (
      .clk(clk), .reset(reset), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .control_signals(control_signals), .pc(pc),
      .data_a(data_a), .data_b(data_b), .store_data(store_data),
      .rd_phys_addr(rd_phys_addr), .pc_value_at_prediction(pc_value_at_prediction),
      .branch_sel(branch_sel), .branch_prediction(branch_prediction),
      .data_result(data_result), .mem_addr_calculation(mem_addr_calculation),
      .misprediction(misprediction), .is_branch(is_branch), .correct_pc(correct_pc),
      .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
      .cdb_data(cdb_data), .cdb_reg_write(cdb_reg_write),
      .cdb_misprediction(cdb_misprediction), .cdb_correct_pc(cdb_correct_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares the CDB head against the scoreboard on every transfer.
   initial begin
      fu_result_t e;
      forever begin
         @(negedge clk);
         if (!reset && !flush && cdb_valid && cdb_ready) begin
            if (sb.size() == 0) begin
               check("cdb unexpected transfer", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("cdb_tag", 64'(cdb_tag), 64'(e.tag));
               check("cdb_data", 64'(cdb_data), 64'(e.data));
               check("cdb_reg_write", 64'(cdb_reg_write), 64'(e.reg_write));
               check("cdb_misprediction", 64'(cdb_misprediction), 64'(e.misprediction));
               check("cdb_correct_pc", 64'(cdb_correct_pc), 64'(e.correct_pc));
            end
         end
      end
   end

   task automatic issue(input string name, input logic [10:0] ctrl, input logic [31:0] pc_v,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                        input logic [5:0] tag, input logic [31:0] ppred, input logic [2:0] bsel,
                        input logic bpred, input logic rdy, input logic fl,
                        input logic [31:0] e_data, input logic [31:0] e_cpc,
                        input logic e_misp, input logic e_acc);
      fu_result_t e;
      @(posedge clk); #1;
      issue_valid = 1'b1; control_signals = ctrl; pc = pc_v;
      data_a = a; data_b = b; store_data = sd; rd_phys_addr = tag;
      pc_value_at_prediction = ppred; branch_sel = bsel; branch_prediction = bpred;
      cdb_ready = rdy; flush = fl;
      @(negedge clk);
      check({name, " data_result"}, 64'(data_result), 64'(e_data));
      check({name, " correct_pc"}, 64'(correct_pc), 64'(e_cpc));
      check({name, " misprediction"}, 64'(misprediction), 64'(e_misp));
      check({name, " is_branch"}, 64'(is_branch), 64'(bsel != 3'd0));
      check({name, " mem_addr"}, 64'(mem_addr_calculation), 64'(ctrl[5]));
      check({name, " issue_ready"}, 64'(issue_ready), 64'(e_acc));
      if (fl) sb.delete();
      if (e_acc) begin
         e.tag = tag; e.data = e_data; e.reg_write = ctrl[4];
         e.misprediction = e_misp; e.correct_pc = e_cpc;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input logic rdy);
      @(posedge clk); #1;
      issue_valid = 1'b0; flush = 1'b0; cdb_ready = rdy;
      @(negedge clk);
   endtask

   task automatic drain();
      int budget = 20;
      while (sb.size() != 0 && budget > 0) begin
         idle(1'b1);
         budget--;
      end
      check("drain completes", 64'(sb.size()), 64'd0);
      idle(1'b1);
      check("empty after drain", 64'(cdb_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset issue_ready", 64'(issue_ready), 64'd1);
      check("reset cdb_valid", 64'(cdb_valid), 64'd0);
      check("reset cdb_tag", 64'(cdb_tag), 64'd0);
      check("reset cdb_data", 64'(cdb_data), 64'd0);
      check("reset cdb_correct_pc", 64'(cdb_correct_pc), 64'd0);
      check("idle data_result", 64'(data_result), 64'd0);
      check("idle correct_pc", 64'(correct_pc), 64'd0);

      // ADD, 1-cycle latency to the CDB, then empty.
      issue("add", 11'h010, 32'h0, 32'd5, 32'd7, 32'd0, 6'd9, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'd12, 32'd4, 1'b0, 1'b1);
      idle(1'b1);
      check("add cdb_valid", 64'(cdb_valid), 64'd1);
      check("add cdb_tag", 64'(cdb_tag), 64'd9);
      idle(1'b1);
      check("add cdb_valid after pop", 64'(cdb_valid), 64'd0);

      // Branches.
      issue("beq mispred", 11'h000, 32'h100, 32'd3, 32'h20, 32'd3, 6'd10, 32'h0, 3'd1, 1'b0, 1'b1, 1'b0,
            32'h23, 32'h120, 1'b1, 1'b1);
      issue("beq correct", 11'h000, 32'h100, 32'd3, 32'h20, 32'd3, 6'd10, 32'h120, 3'd1, 1'b1, 1'b1, 1'b0,
            32'h23, 32'h120, 1'b0, 1'b1);
      issue("bne not taken", 11'h000, 32'h100, 32'd3, 32'h20, 32'd3, 6'd12, 32'h0, 3'd2, 1'b0, 1'b1, 1'b0,
            32'h23, 32'h104, 1'b0, 1'b1);
      issue("blt signed", 11'h000, 32'h100, 32'hFFFFFFFF, 32'h20, 32'd1, 6'd13, 32'h0, 3'd3, 1'b0, 1'b1, 1'b0,
            32'h1F, 32'h120, 1'b1, 1'b1);
      issue("bltu unsigned", 11'h000, 32'h100, 32'hFFFFFFFF, 32'h20, 32'd1, 6'd14, 32'h0, 3'd5, 1'b0, 1'b1, 1'b0,
            32'h1F, 32'h104, 1'b0, 1'b1);
      issue("jalr bad target", 11'h050, 32'h200, 32'h1001, 32'd4, 32'd0, 6'd11, 32'h1000, 3'd7, 1'b1, 1'b1, 1'b0,
            32'h204, 32'h1004, 1'b1, 1'b1);
      issue("jalr good target", 11'h050, 32'h200, 32'h1001, 32'd4, 32'd0, 6'd11, 32'h1004, 3'd7, 1'b1, 1'b1, 1'b0,
            32'h204, 32'h1004, 1'b0, 1'b1);
      drain();

      // Back-pressure: two fill the buffer, the third waits for the first pop.
      issue("sub1", 11'h011, 32'h0, 32'd10, 32'd3, 32'd0, 6'd1, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0,
            32'd7, 32'd4, 1'b0, 1'b1);
      issue("sub2", 11'h011, 32'h0, 32'd8, 32'd8, 32'd0, 6'd2, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0,
            32'd0, 32'd4, 1'b0, 1'b1);
      issue("sub3 stalled", 11'h011, 32'h0, 32'd0, 32'd1, 32'd0, 6'd3, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0,
            32'hFFFFFFFF, 32'd4, 1'b0, 1'b0);
      issue("sub3 accepted", 11'h011, 32'h0, 32'd0, 32'd1, 32'd0, 6'd3, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'hFFFFFFFF, 32'd4, 1'b0, 1'b1);
      drain();

      // Flush with a full buffer and an op presented.
      issue("fill1", 11'h010, 32'h0, 32'd1, 32'd1, 32'd0, 6'd20, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0,
            32'd2, 32'd4, 1'b0, 1'b1);
      issue("fill2", 11'h010, 32'h0, 32'd2, 32'd2, 32'd0, 6'd21, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0,
            32'd4, 32'd4, 1'b0, 1'b1);
      issue("flush issue", 11'h010, 32'h0, 32'd3, 32'd4, 32'd0, 6'd22, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1,
            32'd7, 32'd4, 1'b0, 1'b0);
      idle(1'b1);
      check("flush cdb_valid", 64'(cdb_valid), 64'd0);
      check("flush issue_ready", 64'(issue_ready), 64'd1);
      issue("post-flush add", 11'h010, 32'h0, 32'd6, 32'd6, 32'd0, 6'd23, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'd12, 32'd4, 1'b0, 1'b1);
      drain();

      // ALU corners.
      issue("sra", 11'h017, 32'h0, 32'h80000000, 32'd4, 32'd0, 6'd30, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'hF8000000, 32'd4, 1'b0, 1'b1);
      issue("srl", 11'h016, 32'h0, 32'h80000000, 32'd4, 32'd0, 6'd31, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'h08000000, 32'd4, 1'b0, 1'b1);
      issue("sltu", 11'h014, 32'h0, 32'd1, 32'hFFFFFFFF, 32'd0, 6'd32, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'd1, 32'd4, 1'b0, 1'b1);
      issue("slt", 11'h013, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd0, 6'd33, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'd1, 32'd4, 1'b0, 1'b1);
      issue("sll shamt5", 11'h012, 32'h0, 32'd1, 32'h21, 32'd0, 6'd34, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'd2, 32'd4, 1'b0, 1'b1);
      issue("xor", 11'h015, 32'h0, 32'hF0F0, 32'hFF00, 32'd0, 6'd35, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'h0FF0, 32'd4, 1'b0, 1'b1);
      issue("or", 11'h018, 32'h0, 32'hF0, 32'h0F, 32'd0, 6'd36, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'hFF, 32'd4, 1'b0, 1'b1);
      issue("and", 11'h019, 32'h0, 32'hF0, 32'h3C, 32'd0, 6'd37, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'h30, 32'd4, 1'b0, 1'b1);
      issue("pass_b", 11'h01A, 32'h0, 32'h1234, 32'hDEAD, 32'd0, 6'd38, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'hDEAD, 32'd4, 1'b0, 1'b1);
      issue("alu13", 11'h01D, 32'h0, 32'h55, 32'h66, 32'd0, 6'd39, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'd0, 32'd4, 1'b0, 1'b1);
      issue("auipc", 11'h090, 32'h1000, 32'h77, 32'h5000, 32'd0, 6'd40, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'h6000, 32'h1004, 1'b0, 1'b1);
      issue("mem addr", 11'h020, 32'h0, 32'h1000, 32'h10, 32'd0, 6'd41, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0,
            32'h1010, 32'd4, 1'b0, 1'b1);
      drain();

      // Reset mid-operation clears the buffered payload.
      issue("pre-reset", 11'h010, 32'h0, 32'h100, 32'h23, 32'd0, 6'd42, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0,
            32'h123, 32'd4, 1'b0, 1'b1);
      @(posedge clk); #1;
      issue_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midreset cdb_valid", 64'(cdb_valid), 64'd0);
      check("midreset cdb_data", 64'(cdb_data), 64'd0);
      check("midreset cdb_tag", 64'(cdb_tag), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
